// File: rtl/dds_pkg.sv
// Shared DDS definitions: default widths, sweep sequencer states and dwell helper.
package dds_pkg;

  localparam int unsigned DDS_ACC_W   = 32;
  localparam int unsigned DDS_PHASE_W = 8;
  localparam int unsigned DDS_DWELL_W = 16;
  localparam int unsigned DDS_STEP_W  = 12;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_DWELL = 3'd2,
    S_STEP  = 3'd3,
    S_DONE  = 3'd4
  } sweep_state_e;

  // Counter preload for a dwell of max(dwell,1) cycles.
  function automatic logic [DDS_DWELL_W-1:0] dwell_load(input logic [DDS_DWELL_W-1:0] dwell);
    return (dwell == '0) ? '0 : dwell - DDS_DWELL_W'(1);
  endfunction

endpackage

// File: rtl/dds_dwell_timer.sv
// Loadable down-counter with terminal-count flag; load has priority over decrement.
module dds_dwell_timer #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic [W-1:0] count,
  output logic         tc_c
);

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - W'(1);
    end
  end

  assign tc_c = (count == '0);

endmodule

// File: rtl/dds_sweep_ctrl.sv
// Frequency-sweep sequencer: steps the DDS tuning word from a latched start value
// by a fixed increment every dwell period, optionally restarting continuously.
module dds_sweep_ctrl
  import dds_pkg::*;
#(
  parameter int unsigned ACC_W   = DDS_ACC_W,
  parameter int unsigned PHASE_W = DDS_PHASE_W,
  parameter int unsigned DWELL_W = DDS_DWELL_W,
  parameter int unsigned STEP_W  = DDS_STEP_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
  input  logic               cont,
  input  logic [ACC_W-1:0]   f_start,
  input  logic [ACC_W-1:0]   f_step,
  input  logic [STEP_W-1:0]  n_steps,
  input  logic [DWELL_W-1:0] dwell,
  input  logic [PHASE_W-1:0] phase_in,
  output logic [ACC_W-1:0]   tuning_word,
  output logic [PHASE_W-1:0] phase_out,
  output logic               dds_en,
  output logic               dds_phase_rst,
  output logic               busy,
  output logic               done,
  output logic [STEP_W-1:0]  step_idx
);

  sweep_state_e       state;
  logic [ACC_W-1:0]   f_start_q;
  logic [ACC_W-1:0]   f_step_q;
  logic [STEP_W-1:0]  n_steps_q;
  logic [DWELL_W-1:0] dwell_ld_q;
  logic               cont_q;

  logic [DWELL_W-1:0] dwell_ld_c;
  logic [DWELL_W-1:0] tmr_val_c;
  logic [DWELL_W-1:0] tmr_count;
  logic               tmr_load_c;
  logic               tmr_dec_c;
  logic               tmr_tc_c;
  logic               active_c;
  sweep_state_e       after_step_c;

  assign dwell_ld_c   = DWELL_W'(dwell_load(DDS_DWELL_W'(dwell)));
  assign active_c     = (state == S_LOAD) || (state == S_DWELL) || (state == S_STEP);
  // A zero preload means every cycle is the last of its dwell period.
  assign after_step_c = (dwell_ld_q == '0) ? S_STEP : S_DWELL;

  // Dwell timer control: preload on start and on every step, otherwise count down.
  always_comb begin
    tmr_load_c = 1'b0;
    tmr_dec_c  = 1'b0;
    tmr_val_c  = dwell_ld_q;
    if (!abort) begin
      if (state == S_IDLE) begin
        if (start) begin
          tmr_load_c = 1'b1;
          tmr_val_c  = dwell_ld_c;
        end
      end else if (active_c) begin
        if (tmr_tc_c) begin
          tmr_load_c = 1'b1;
        end else begin
          tmr_dec_c = 1'b1;
        end
      end
    end
  end

  dds_dwell_timer #(
    .W (DWELL_W)
  ) u_dwell_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load_c),
    .load_val (tmr_val_c),
    .dec      (tmr_dec_c),
    .count    (tmr_count),
    .tc_c     (tmr_tc_c)
  );

  // Sequencer state and all registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_IDLE;
      tuning_word   <= '0;
      phase_out     <= '0;
      step_idx      <= '0;
      dds_en        <= 1'b0;
      dds_phase_rst <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      f_start_q     <= '0;
      f_step_q      <= '0;
      n_steps_q     <= '0;
      dwell_ld_q    <= '0;
      cont_q        <= 1'b0;
    end else begin
      dds_phase_rst <= 1'b0;
      done          <= 1'b0;
      if (abort) begin
        state  <= S_IDLE;
        dds_en <= 1'b0;
        busy   <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            if (start) begin
              f_start_q     <= f_start;
              f_step_q      <= f_step;
              n_steps_q     <= n_steps;
              dwell_ld_q    <= dwell_ld_c;
              cont_q        <= cont;
              tuning_word   <= f_start;
              phase_out     <= phase_in;
              step_idx      <= '0;
              dds_phase_rst <= 1'b1;
              dds_en        <= 1'b1;
              busy          <= 1'b1;
              state         <= S_LOAD;
            end
          end
          S_LOAD, S_DWELL, S_STEP: begin
            if (tmr_tc_c) begin
              if (step_idx == n_steps_q) begin
                if (cont_q) begin
                  tuning_word   <= f_start_q;
                  step_idx      <= '0;
                  dds_phase_rst <= 1'b1;
                  state         <= after_step_c;
                end else begin
                  busy   <= 1'b0;
                  dds_en <= 1'b0;
                  done   <= 1'b1;
                  state  <= S_DONE;
                end
              end else begin
                tuning_word <= tuning_word + f_step_q;
                step_idx    <= step_idx + STEP_W'(1);
                state       <= after_step_c;
              end
            end else begin
              state <= (tmr_count == DWELL_W'(1)) ? S_STEP : S_DWELL;
            end
          end
          S_DONE:  state <= S_IDLE;
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// Self-checking bench for dds_sweep_ctrl against a per-cycle sweep reference model.
module tb_dds_sweep_ctrl;

  localparam int unsigned ACC_W   = 32;
  localparam int unsigned PHASE_W = 8;
  localparam int unsigned DWELL_W = 16;
  localparam int unsigned STEP_W  = 12;

  logic               clk = 1'b0;
  logic               rst;
  logic               start;
  logic               abort;
  logic               cont;
  logic [ACC_W-1:0]   f_start;
  logic [ACC_W-1:0]   f_step;
  logic [STEP_W-1:0]  n_steps;
  logic [DWELL_W-1:0] dwell;
  logic [PHASE_W-1:0] phase_in;
  logic [ACC_W-1:0]   tuning_word;
  logic [PHASE_W-1:0] phase_out;
  logic               dds_en;
  logic               dds_phase_rst;
  logic               busy;
  logic               done;
  logic [STEP_W-1:0]  step_idx;

  dds_sweep_ctrl dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .abort         (abort),
    .cont          (cont),
    .f_start       (f_start),
    .f_step        (f_step),
    .n_steps       (n_steps),
    .dwell         (dwell),
    .phase_in      (phase_in),
    .tuning_word   (tuning_word),
    .phase_out     (phase_out),
    .dds_en        (dds_en),
    .dds_phase_rst (dds_phase_rst),
    .busy          (busy),
    .done          (done),
    .step_idx      (step_idx)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] word;
    int          idx;
    bit          busy;
    bit          en;
    bit          prst;
    bit          done;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Expected outputs for cycles 1..nc after the start edge (index 0 is cycle 1).
  task automatic build(input logic [31:0] fs, input logic [31:0] fstep, input int n,
                       input int d, input bit c, input int nc, input int ab);
    int   dd;
    exp_t e;
    dd = (d == 0) ? 1 : d;
    exp_q.delete();
    while (exp_q.size() < nc) begin
      for (int i = 0; i <= n; i++) begin
        for (int j = 0; j < dd; j++) begin
          e.word = fs + fstep * 32'(i);
          e.idx  = i;
          e.busy = 1'b1;
          e.en   = 1'b1;
          e.prst = (i == 0) && (j == 0);
          e.done = 1'b0;
          exp_q.push_back(e);
        end
      end
      if (!c) begin
        e.busy = 1'b0;
        e.en   = 1'b0;
        e.prst = 1'b0;
        e.done = 1'b1;
        exp_q.push_back(e);
        e.done = 1'b0;
        while (exp_q.size() < nc) exp_q.push_back(e);
      end
    end
    while (exp_q.size() > nc) void'(exp_q.pop_back());
    if (ab > 0 && ab < nc) begin
      e      = exp_q[ab-1];
      e.busy = 1'b0;
      e.en   = 1'b0;
      e.prst = 1'b0;
      e.done = 1'b0;
      for (int k = ab; k < nc; k++) exp_q[k] = e;
    end
  endtask

  task automatic scramble_cfg();
    f_start  = $urandom;
    f_step   = $urandom;
    n_steps  = STEP_W'($urandom);
    dwell    = DWELL_W'($urandom);
    phase_in = PHASE_W'($urandom);
    cont     = 1'($urandom);
  endtask

  task automatic check_zero(input string name);
    check({name, " tw"},   64'(tuning_word),   64'(0));
    check({name, " ph"},   64'(phase_out),     64'(0));
    check({name, " idx"},  64'(step_idx),      64'(0));
    check({name, " en"},   64'(dds_en),        64'(0));
    check({name, " prst"}, 64'(dds_phase_rst), 64'(0));
    check({name, " busy"}, 64'(busy),          64'(0));
    check({name, " done"}, 64'(done),          64'(0));
  endtask

  // Called at a negedge; issues start there and checks nc cycles afterwards.
  task automatic run_sweep(input string name, input logic [31:0] fs, input logic [31:0] fstep,
                           input int n, input int d, input bit c, input logic [7:0] ph,
                           input int nc, input int ab, input int bs);
    build(fs, fstep, n, d, c, nc, ab);
    f_start  = fs;
    f_step   = fstep;
    n_steps  = STEP_W'(n);
    dwell    = DWELL_W'(d);
    cont     = c;
    phase_in = ph;
    abort    = 1'b0;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    scramble_cfg();
    for (int cy = 1; cy <= nc; cy++) begin
      check($sformatf("%s c%0d tw", name, cy),   64'(tuning_word),   64'(exp_q[cy-1].word));
      check($sformatf("%s c%0d idx", name, cy),  64'(step_idx),      64'(exp_q[cy-1].idx));
      check($sformatf("%s c%0d ph", name, cy),   64'(phase_out),     64'(ph));
      check($sformatf("%s c%0d busy", name, cy), 64'(busy),          64'(exp_q[cy-1].busy));
      check($sformatf("%s c%0d en", name, cy),   64'(dds_en),        64'(exp_q[cy-1].en));
      check($sformatf("%s c%0d prst", name, cy), 64'(dds_phase_rst), 64'(exp_q[cy-1].prst));
      check($sformatf("%s c%0d done", name, cy), 64'(done),          64'(exp_q[cy-1].done));
      abort = (cy == ab);
      start = (cy == bs);
      if (start) scramble_cfg();
      @(negedge clk);
    end
    abort = 1'b0;
    start = 1'b0;
  endtask

  initial begin
    int n, d, len, nc, ab, bs;
    bit c;
    rst = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    scramble_cfg();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_zero("reset");
    rst = 1'b0;
    @(negedge clk);

    run_sweep("basic", 32'h0100_0000, 32'h0010_0000, 3, 4, 1'b0, 8'h11, 20, 0, 0);
    run_sweep("wrap",  32'hFFFF_FFF0, 32'h0000_0020, 1, 2, 1'b0, 8'h22, 6, 0, 0);
    run_sweep("dw0",   32'h0000_1000, 32'h0000_0100, 2, 0, 1'b0, 8'h33, 6, 0, 0);
    run_sweep("ns0",   32'h1234_5678, 32'h0000_0001, 0, 5, 1'b0, 8'h44, 8, 0, 0);
    run_sweep("cont",  32'h0A00_0000, 32'h0000_0400, 1, 3, 1'b1, 8'h55, 20, 19, 0);
    run_sweep("abort", 32'h0100_0000, 32'h0010_0000, 3, 4, 1'b0, 8'h66, 10, 6, 3);

    // Reset mid-dwell, then a clean sweep one cycle after release.
    run_sweep("pre_rst", 32'h0100_0000, 32'h0010_0000, 3, 4, 1'b0, 8'h77, 6, 0, 0);
    rst = 1'b1;
    @(negedge clk);
    check_zero("mid_rst");
    rst = 1'b0;
    @(negedge clk);
    run_sweep("post_rst", 32'h0200_0000, 32'h0001_0000, 2, 2, 1'b0, 8'h40, 9, 0, 0);

    for (int it = 0; it < 10; it++) begin
      n   = $urandom_range(0, 4);
      d   = $urandom_range(0, 4);
      c   = 1'($urandom_range(0, 1));
      len = (n + 1) * ((d == 0) ? 1 : d);
      nc  = len + 3 + (c ? len : 0);
      ab  = c ? nc - 1 : (($urandom_range(0, 2) == 0) ? $urandom_range(1, len) : 0);
      bs  = (len >= 2) ? $urandom_range(1, len - 1) : 0;
      if (ab != 0 && bs >= ab) bs = 0;
      run_sweep($sformatf("rnd%0d", it), $urandom, $urandom, n, d, c,
                8'($urandom), nc, ab, bs);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dds_sweep_ctrl.md
# dds_sweep_ctrl

Frequency-sweep sequencer for the signed-sine DDS core. It latches a sweep configuration on a start strobe, then drives the core's tuning word, enable and phase controls. The tuning word starts at a start value and advances by a fixed step every dwell period until the programmed step count is reached. The block sits between the host/configuration logic and the DDS core and is the only writer of the core's frequency and phase inputs.

## Interface
- ACC_W, 32, tuning-word / phase-accumulator width
- PHASE_W, 8, phase-offset width (matches DDS `phase` input)
- DWELL_W, 16, dwell counter width
- STEP_W, 12, step counter width

- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- start  in  1  sweep request strobe, sampled in IDLE only
- abort  in  1  terminate sweep, any state
- cont  in  1  0: single sweep; 1: restart from f_start after last step
- f_start  in  ACC_W  initial tuning word
- f_step  in  ACC_W  tuning-word increment per step (unsigned, modulo 2^ACC_W)
- n_steps  in  STEP_W  number of increments after the start word
- dwell  in  DWELL_W  cycles each tuning word is held (0 treated as 1)
- phase_in  in  PHASE_W  phase offset latched with start
- tuning_word  out  ACC_W  frequency control to DDS core
- phase_out  out  PHASE_W  phase offset to DDS core
- dds_en  out  1  DDS accumulator enable
- dds_phase_rst  out  1  one-cycle accumulator clear
- busy  out  1  sweep in progress
- done  out  1  one-cycle completion pulse
- step_idx  out  STEP_W  index of current tuning word

## Operation
- States: IDLE, LOAD, DWELL, STEP, DONE.
- IDLE: busy=0, dds_en=0. tuning_word, phase_out and step_idx hold their last values. start=1 and abort=0 latch all config inputs and go to LOAD.
- LOAD (1 cycle): tuning_word=f_start, phase_out=latched phase, step_idx=0, dds_phase_rst=1, dds_en=1, busy=1. The dwell counter loads max(dwell,1)-1. This cycle counts as the first dwell cycle of step 0. If the counter loads 0, go to STEP; otherwise go to DWELL.
- DWELL: the counter decrements each cycle. Go to STEP in the cycle it reaches 0.
- STEP (combined with the last dwell cycle; it adds no extra cycle):
  - if step_idx == n_steps and cont=0, go to DONE;
  - if step_idx == n_steps and cont=1, reload f_start, set step_idx=0 and pulse dds_phase_rst;
  - otherwise tuning_word += f_step (wraps mod 2^ACC_W, no saturation), step_idx++ and the counter reloads.
- DONE (1 cycle): done=1, busy=0, dds_en=0, then go to IDLE.
- abort has priority over everything. Any state goes to IDLE at the next edge, with no done pulse and dds_en=0. When start and abort arrive in the same cycle in IDLE, abort wins.
- start while busy is ignored.
- Config inputs are don't-care after the start cycle; only the latched copies are used.
- n_steps=0: a single tuning word is held for max(dwell,1) cycles.

## Timing
- Reset: state=IDLE, and tuning_word, phase_out, step_idx, dds_en, dds_phase_rst, busy and done are all 0.
- rst asserted mid-sweep behaves exactly like reset; no done pulse.
- Latency:
  - start sampled at edge k;
  - busy, dds_en, dds_phase_rst and tuning_word=f_start are valid from cycle k+1;
  - each tuning word is held for exactly max(dwell,1) cycles;
  - single sweep: busy is high for (n_steps+1)·max(dwell,1) cycles, and done pulses in the following cycle.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Structure
- Package dds_pkg holds:
  - the state enum;
  - ACC_W and PHASE_W defaults, shared with the DDS core;
  - a helper function dwell_load(dwell) returning max(dwell,1)-1.
- Sub-module dds_dwell_timer: a loadable down-counter with a terminal-count output, reused by other DDS sequencers.

## Test plan
- Basic sweep:
  - stimulus: f_start=0x0100_0000, f_step=0x0010_0000, n_steps=3, dwell=4, cont=0;
  - tuning_word is 0x01000000, 0x01100000, 0x01200000, 0x01300000, 4 cycles each;
  - busy is high 16 cycles, done pulses once in cycle 17, dds_phase_rst is high only in cycle 1.
- Wrap: f_start=0xFFFF_FFF0, f_step=0x20, n_steps=1, dwell=2 -> second tuning word is 0x0000_0010, no error flag.
- Zero dwell / zero steps:
  - dwell=0, n_steps=2 -> a new tuning word every cycle, busy for 3 cycles;
  - n_steps=0, dwell=5 -> a single word held 5 cycles.
- Continuous: cont=1, n_steps=1, dwell=3 -> the word pattern repeats every 6 cycles, dds_phase_rst pulses on each restart, done is never asserted.
- Abort: abort in cycle 6 of the basic sweep -> busy=0 and dds_en=0 at the next edge, no done. A start applied while busy earlier in the sweep is ignored.
- Reset: rst in mid-DWELL -> all outputs 0 next cycle; a start one cycle after rst deasserts begins a clean sweep with phase_in=0x40 reflected on phase_out.
